// File: rtl/axi_burst_writer.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_writer
// Purpose  : Issues one AXI4 write burst per accepted command. The address
//            phase is followed by cmd_len+1 data beats whose payload counts
//            up from cmd_seed. The write response then closes the burst
//            with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   ASIZE  address width             DSIZE  data width
//   LSIZE  burst length field width  ID     constant value on axi_awid
// Ports:
//   axi_aclk, axi_aresetn        clock, synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only while idle)
//   cmd_addr/cmd_len/cmd_seed    start address, beats-1, first data word
//   axi_aw*                      AXI write address channel
//   axi_w*                       AXI write data channel
//   axi_b*                       AXI write response channel
//   done, err                    end-of-burst pulse; err flags a non-OKAY
//                                response or a watchdog abort
// Build option:
//   AXI_WRITER_TIMEOUT_EN        adds a 10-bit no-progress watchdog. After
//                                1024 stalled cycles it aborts the burst
//                                with done=1 and err=1.
// ============================================================================
module axi_burst_writer #(
  parameter int ASIZE = 32,
  parameter int DSIZE = 64,
  parameter int LSIZE = 8,
  parameter int ID    = 0
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ASIZE-1:0] cmd_addr,
  input  logic [LSIZE-1:0] cmd_len,
  input  logic [DSIZE-1:0] cmd_seed,
  output logic [3:0]       axi_awid,
  output logic [ASIZE-1:0] axi_awaddr,
  output logic [LSIZE-1:0] axi_awlen,
  output logic             axi_awvalid,
  input  logic             axi_awready,
  output logic [DSIZE-1:0] axi_wdata,
  output logic             axi_wvalid,
  input  logic             axi_wready,
  output logic             axi_wlast,
  input  logic [1:0]       axi_bresp,
  input  logic             axi_bvalid,
  output logic             axi_bready,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2,
    S_B    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic [LSIZE-1:0] len_q, len_d;
  logic [DSIZE-1:0] data_q, data_d;   // payload of the beat currently offered
  logic [LSIZE-1:0] beat_q, beat_d;   // index of the beat currently offered

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic last_beat;
  logic timeout;

  assign aw_hs     = (state_q == S_AW) && axi_awready;
  assign w_hs      = (state_q == S_W)  && axi_wready;
  assign b_hs      = (state_q == S_B)  && axi_bvalid;
  assign last_beat = (beat_q == len_q);

`ifdef AXI_WRITER_TIMEOUT_EN
  logic [9:0] wdog_q, wdog_d;

  // The counter holds the number of consecutive stalled cycles spent in the
  // current channel. The abort fires on the 1024th such cycle.
  always_comb begin
    wdog_d = wdog_q;
    if ((state_q == S_IDLE) || aw_hs || w_hs || b_hs) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + 10'd1;
    end
  end

  assign timeout = (state_q != S_IDLE) && !(aw_hs || w_hs || b_hs) &&
                   (wdog_q == 10'h3FF);

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state, datapath and the done/err pulse
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    data_d  = data_q;
    beat_d  = beat_q;
    done    = 1'b0;
    err     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          data_d  = cmd_seed;
          beat_d  = '0;
          state_d = S_AW;
        end
      end
      S_AW: begin
        if (aw_hs) begin
          state_d = S_W;
        end
      end
      S_W: begin
        if (w_hs) begin
          if (last_beat) begin
            state_d = S_B;
          end else begin
            beat_d = beat_q + 1'b1;
            data_d = data_q + 1'b1;   // wraps modulo 2^DSIZE
          end
        end
      end
      S_B: begin
        if (b_hs) begin
          done    = 1'b1;
          err     = (axi_bresp != 2'b00);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      state_d = S_IDLE;
      done    = 1'b1;
      err     = 1'b1;
    end

    // A burst interrupted by reset is discarded silently
    if (!axi_aresetn) begin
      done = 1'b0;
      err  = 1'b0;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      data_q  <= data_d;
      beat_q  <= beat_d;
    end
  end

  assign cmd_ready   = axi_aresetn && (state_q == S_IDLE);
  assign axi_awid    = 4'(ID);
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = len_q;
  assign axi_awvalid = (state_q == S_AW);
  assign axi_wdata   = data_q;
  assign axi_wvalid  = (state_q == S_W);
  assign axi_wlast   = (state_q == S_W) && last_beat;
  assign axi_bready  = (state_q == S_B);

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_burst_writer
// Purpose  : Directed self-checking bench for axi_burst_writer. A simple
//            AXI slave answers the channels. A monitor records address,
//            data beats and done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_burst_writer;

  logic        clk;
  logic        axi_aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [63:0] cmd_seed;
  logic [3:0]  axi_awid;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [63:0] axi_wdata;
  logic        axi_wvalid;
  logic        axi_wready;
  logic        axi_wlast;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic        done;
  logic        err;

  axi_burst_writer #(
    .ASIZE(32), .DSIZE(64), .LSIZE(8), .ID(0)
  ) u_dut (
    .axi_aclk    (clk),
    .axi_aresetn (axi_aresetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_seed    (cmd_seed),
    .axi_awid    (axi_awid),
    .axi_awaddr  (axi_awaddr),
    .axi_awlen   (axi_awlen),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_wlast   (axi_wlast),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave knobs
  logic awready_en    = 1'b1;
  logic wready_toggle = 1'b0;
  logic bvalid_force  = 1'b0;

  // Slave responder updates on the falling edge
  always @(negedge clk) begin
    axi_awready = awready_en;
    axi_wready  = wready_toggle ? ~axi_wready : 1'b1;
    axi_bvalid  = axi_bready | bvalid_force;
  end

  // Monitor samples 2 ns before each rising edge
  int          cyc      = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          acc_cyc  = 0;
  int          aw_cnt   = 0;
  logic [31:0] aw_addr_seen;
  logic [7:0]  aw_len_seen;
  logic [63:0] wq[$];
  logic        lq[$];
  logic        errs[$];
  logic        stab_en    = 1'b0;
  logic        stall_prev = 1'b0;
  logic [63:0] stall_data;

  always @(negedge clk) begin
    #3;
    cyc++;
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (axi_awvalid) check_value("wvalid_in_aw", {63'd0, axi_wvalid}, 64'd0);
    if (axi_awvalid && axi_awready) begin
      aw_addr_seen = axi_awaddr;
      aw_len_seen  = axi_awlen;
      aw_cnt++;
    end
    if (stab_en && stall_prev) begin
      check_value("wvalid_stable", {63'd0, axi_wvalid}, 64'd1);
      check_value("wdata_stable", axi_wdata, stall_data);
    end
    stall_prev = axi_wvalid && !axi_wready;
    stall_data = axi_wdata;
    if (axi_wvalid && axi_wready) begin
      wq.push_back(axi_wdata);
      lq.push_back(axi_wlast);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      errs.push_back(err);
    end
  end

  task automatic clear_log();
    wq.delete();
    lq.delete();
    errs.delete();
    aw_cnt = 0;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [7:0] l,
                          input logic [63:0] s);
    logic acc;
    acc = 1'b0;
    @(negedge clk);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_seed  = s;
    cmd_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      #1;
      if (cmd_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_value("cmd_accepted", {63'd0, acc}, 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #4;
      if (done_cnt > start) break;
    end
    check_value("done_seen", {63'd0, (done_cnt > start)}, 64'd1);
  endtask

  task automatic check_beats(input int n, input logic [63:0] seed);
    logic [63:0] exp_d;
    check_value("beat_count", 64'(wq.size()), 64'(n));
    for (int k = 0; k < n && k < wq.size(); k++) begin
      exp_d = seed + 64'(k);
      check_value($sformatf("wdata[%0d]", k), wq[k], exp_d);
      check_value($sformatf("wlast[%0d]", k), {63'd0, lq[k]},
                  {63'd0, (k == n - 1)});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    axi_aresetn = 1'b0;
    cmd_valid   = 1'b0;
    cmd_addr    = '0;
    cmd_len     = '0;
    cmd_seed    = '0;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bresp   = 2'b00;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_value("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check_value("rst_awvalid", {63'd0, axi_awvalid}, 64'd0);
    check_value("rst_wvalid", {63'd0, axi_wvalid}, 64'd0);
    check_value("rst_wlast", {63'd0, axi_wlast}, 64'd0);
    check_value("rst_bready", {63'd0, axi_bready}, 64'd0);
    check_value("rst_done", {63'd0, done}, 64'd0);
    check_value("rst_err", {63'd0, err}, 64'd0);
    axi_aresetn = 1'b1;
    @(negedge clk);
    #1;
    check_value("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // Basic 4-beat burst
    clear_log();
    send_cmd(32'h1000, 8'd3, 64'h10);
    wait_done(200);
    check_value("awaddr", {32'd0, aw_addr_seen}, 64'h1000);
    check_value("awlen", {56'd0, aw_len_seen}, 64'd3);
    check_value("aw_count", 64'(aw_cnt), 64'd1);
    check_value("awid", {60'd0, axi_awid}, 64'd0);
    check_beats(4, 64'h10);
    check_value("err_ok", {63'd0, errs[0]}, 64'd0);

    // Single beat with all-ones seed
    clear_log();
    send_cmd(32'h2000, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(200);
    check_beats(1, 64'hFFFF_FFFF_FFFF_FFFF);

    // Two beats, data wraps to zero on beat 1
    clear_log();
    send_cmd(32'h3000, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(200);
    check_beats(2, 64'hFFFF_FFFF_FFFF_FFFF);
    check_value("wrap_beat1", wq[1], 64'h0);

    // Stray bvalid in IDLE is ignored
    d0 = done_cnt;
    bvalid_force = 1'b1;
    axi_bresp    = 2'b10;
    repeat (3) @(negedge clk);
    #4;
    check_value("stray_b_no_done", 64'(done_cnt), 64'(d0));
    check_value("stray_b_ready", {63'd0, cmd_ready}, 64'd1);
    bvalid_force = 1'b0;
    axi_bresp    = 2'b00;

    // wready toggling, 8 beats with stall stability checks
    clear_log();
    stab_en       = 1'b1;
    wready_toggle = 1'b1;
    send_cmd(32'h4000, 8'd7, 64'h100);
    wait_done(300);
    check_beats(8, 64'h100);
    wready_toggle = 1'b0;
    stab_en       = 1'b0;

    // SLVERR response, then back-to-back command
    clear_log();
    axi_bresp = 2'b10;
    send_cmd(32'h5000, 8'd1, 64'h200);
    send_cmd(32'h6000, 8'd0, 64'h300);
    check_value("b2b_gap", 64'(acc_cyc - done_cyc), 64'd1);
    wait_done(200);
    check_value("slverr_cnt", 64'(errs.size()), 64'd2);
    check_value("slverr_err0", {63'd0, errs[0]}, 64'd1);
    check_value("slverr_err1", {63'd0, errs[1]}, 64'd1);
    axi_bresp = 2'b00;

    // Reset during beat 2 of 4
    clear_log();
    send_cmd(32'h7000, 8'd3, 64'h20);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #4;
      if (wq.size() >= 2) break;
    end
    @(negedge clk);
    d0 = done_cnt;
    check_value("mid_beat2_data", axi_wdata, 64'h22);
    axi_aresetn = 1'b0;
    @(posedge clk);
    #1;
    check_value("mid_rst_wvalid", {63'd0, axi_wvalid}, 64'd0);
    check_value("mid_rst_awvalid", {63'd0, axi_awvalid}, 64'd0);
    check_value("mid_rst_bready", {63'd0, axi_bready}, 64'd0);
    repeat (2) @(negedge clk);
    axi_aresetn = 1'b1;
    repeat (2) @(negedge clk);
    #4;
    check_value("mid_rst_no_done", 64'(done_cnt), 64'(d0));
    clear_log();
    send_cmd(32'h8000, 8'd2, 64'h55);
    wait_done(200);
    check_beats(3, 64'h55);
    check_value("after_rst_err", {63'd0, errs[0]}, 64'd0);

    // awready held low
    clear_log();
    awready_en = 1'b0;
    d0 = done_cnt;
    send_cmd(32'h9000, 8'd0, 64'h1);
`ifdef AXI_WRITER_TIMEOUT_EN
    wait_done(1200);
    check_value("wdog_latency", 64'(done_cyc - acc_cyc), 64'd1024);
    check_value("wdog_err", {63'd0, errs[0]}, 64'd1);
    check_value("wdog_idle", {63'd0, cmd_ready}, 64'd1);
`else
    repeat (1100) @(negedge clk);
    #4;
    check_value("stall_awvalid", {63'd0, axi_awvalid}, 64'd1);
    check_value("stall_no_done", 64'(done_cnt), 64'(d0));
    axi_aresetn = 1'b0;
    repeat (2) @(negedge clk);
    axi_aresetn = 1'b1;
`endif
    awready_en = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
